// File: rtl/vreg_pkg.sv
// Shared vector-register constants and writeback requester ids, used by the
// register file, the execution units and the writeback scheduler.
package vreg_pkg;

    localparam int unsigned VLEN  = 64;
    localparam int unsigned NREG  = 32;
    localparam int unsigned IDX_W = 5;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the ALU and LSU writeback requesters.
// The pointer names the requester that wins when both are valid.
module rr_arb2
    import vreg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_alu,
    input  logic req_lsu,
    output logic gnt_alu,
    output logic gnt_lsu
);

    req_id_e ptr;

    always_comb begin
        gnt_alu = 1'b0;
        gnt_lsu = 1'b0;
        if (!rst) begin
            if (req_alu && (!req_lsu || ptr == REQ_ALU)) begin
                gnt_alu = 1'b1;
            end else if (req_lsu) begin
                gnt_lsu = 1'b1;
            end
        end
    end

    // After a grant, the loser of this round becomes the favoured requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ_ALU;
        end else if (gnt_alu) begin
            ptr <= REQ_LSU;
        end else if (gnt_lsu) begin
            ptr <= REQ_ALU;
        end
    end

endmodule

// File: rtl/vreg_wb_sched.sv
// Vector register writeback scheduler: pending-write scoreboard for issue
// hazards plus a registered, arbitrated single write port to the file.
module vreg_wb_sched
    import vreg_pkg::*;
#(
    parameter int unsigned VLEN  = vreg_pkg::VLEN,
    parameter int unsigned NREG  = vreg_pkg::NREG,
    parameter int unsigned IDX_W = vreg_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [IDX_W-1:0] iss_vd,
    input  logic [IDX_W-1:0] iss_vs1,
    input  logic [IDX_W-1:0] iss_vs2,
    output logic             iss_stall,
    input  logic             alu_valid,
    input  logic [IDX_W-1:0] alu_vd,
    input  logic [VLEN-1:0]  alu_wdata,
    output logic             alu_ready,
    input  logic             lsu_valid,
    input  logic [IDX_W-1:0] lsu_vd,
    input  logic [VLEN-1:0]  lsu_wdata,
    output logic             lsu_ready,
    output logic             wen,
    output logic [IDX_W-1:0] vd,
    output logic [VLEN-1:0]  wdata,
    output logic [NREG-1:0]  busy,
    output logic             idle
);

    logic            iss_accept;
    logic [NREG-1:0] busy_nxt;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_alu (alu_valid),
        .req_lsu (lsu_valid),
        .gnt_alu (alu_ready),
        .gnt_lsu (lsu_ready)
    );

    assign iss_stall  = !rst && iss_valid &&
                        (busy[iss_vs1] || busy[iss_vs2] || busy[iss_vd]);
    assign iss_accept = !rst && iss_valid && !iss_stall;
    assign idle       = (busy == '0) && !wen;

    // Clear retires the write on the file port; set and clear never hit the
    // same index because a busy destination stalls the issue.
    always_comb begin
        busy_nxt = busy;
        if (wen) begin
            busy_nxt[vd] = 1'b0;
        end
        if (iss_accept) begin
            busy_nxt[iss_vd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen   <= 1'b0;
            vd    <= '0;
            wdata <= '0;
        end else begin
            wen <= alu_ready || lsu_ready;
            if (alu_ready) begin
                vd    <= alu_vd;
                wdata <= alu_wdata;
            end else if (lsu_ready) begin
                vd    <= lsu_vd;
                wdata <= lsu_wdata;
            end
        end
    end

endmodule

// File: tb/tb_vreg_wb_sched.sv
// Directed bench for vreg_wb_sched: a per-cycle vector table with
// hand-computed expectations, plus round-robin and mid-operation reset sequences.
module tb_vreg_wb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_vd, iss_vs1, iss_vs2;
    logic        iss_stall;
    logic        alu_valid;
    logic [4:0]  alu_vd;
    logic [63:0] alu_wdata;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_vd;
    logic [63:0] lsu_wdata;
    logic        lsu_ready;
    logic        wen;
    logic [4:0]  vd;
    logic [63:0] wdata;
    logic [31:0] busy;
    logic        idle;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vreg_wb_sched #(.VLEN(64), .NREG(32), .IDX_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_vd    (iss_vd),
        .iss_vs1   (iss_vs1),
        .iss_vs2   (iss_vs2),
        .iss_stall (iss_stall),
        .alu_valid (alu_valid),
        .alu_vd    (alu_vd),
        .alu_wdata (alu_wdata),
        .alu_ready (alu_ready),
        .lsu_valid (lsu_valid),
        .lsu_vd    (lsu_vd),
        .lsu_wdata (lsu_wdata),
        .lsu_ready (lsu_ready),
        .wen       (wen),
        .vd        (vd),
        .wdata     (wdata),
        .busy      (busy),
        .idle      (idle)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  ivd, ivs1, ivs2;
        logic        av;
        logic [4:0]  avd;
        logic [63:0] ad;
        logic        lv;
        logic [4:0]  lvd;
        logic [63:0] ld;
        logic        stall, ar, lr;
        logic        wen;
        logic [4:0]  vd;
        logic [63:0] wd;
        logic [31:0] busy;
        logic        idle;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(
        input logic r, iv, input logic [4:0] ivd, ivs1, ivs2,
        input logic av, input logic [4:0] avd, input logic [63:0] ad,
        input logic lv, input logic [4:0] lvd, input logic [63:0] ld,
        input logic st, ar, lr, w, input logic [4:0] v, input logic [63:0] wd,
        input logic [31:0] b, input logic id);
        vec_t t;
        t.rst = r;  t.iv = iv;  t.ivd = ivd; t.ivs1 = ivs1; t.ivs2 = ivs2;
        t.av = av;  t.avd = avd; t.ad = ad;
        t.lv = lv;  t.lvd = lvd; t.ld = ld;
        t.stall = st; t.ar = ar; t.lr = lr;
        t.wen = w; t.vd = v; t.wd = wd; t.busy = b; t.idle = id;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, iv, input logic [4:0] ivd, ivs1, ivs2,
                         input logic av, input logic [4:0] avd, input logic [63:0] ad,
                         input logic lv, input logic [4:0] lvd, input logic [63:0] ld);
        rst = r;
        iss_valid = iv; iss_vd = ivd; iss_vs1 = ivs1; iss_vs2 = ivs2;
        alu_valid = av; alu_vd = avd; alu_wdata = ad;
        lsu_valid = lv; lsu_vd = lvd; lsu_wdata = ld;
    endtask

    // Inputs change 1 time unit after a rising edge; combinational outputs are
    // sampled 3 units later, registered outputs 1 unit after the next edge.
    task automatic run_vec(input vec_t t, input int i);
        drive(t.rst, t.iv, t.ivd, t.ivs1, t.ivs2, t.av, t.avd, t.ad, t.lv, t.lvd, t.ld);
        #3;
        chk("iss_stall", i, 64'(iss_stall), 64'(t.stall));
        chk("alu_ready", i, 64'(alu_ready), 64'(t.ar));
        chk("lsu_ready", i, 64'(lsu_ready), 64'(t.lr));
        @(posedge clk);
        #1;
        chk("wen",   i, 64'(wen),   64'(t.wen));
        chk("vd",    i, 64'(vd),    64'(t.vd));
        chk("wdata", i, wdata,      t.wd);
        chk("busy",  i, 64'(busy),  64'(t.busy));
        chk("idle",  i, 64'(idle),  64'(t.idle));
    endtask

    task automatic idle_in(input logic r);
        drive(r, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    initial begin
        //             rst iv ivd ivs1 ivs2 av avd ad            lv lvd ld          st ar lr wen vd  wd            busy          idle
        tbl[0]  = mk(1, 1, 5'd3, 5'd0, 5'd0, 1, 5'd3, 64'h1,         1, 5'd4,  64'h2,    0, 0, 0, 0, 5'd0, 64'h0,         32'h0,        1);
        tbl[1]  = mk(0, 1, 5'd3, 5'd1, 5'd2, 0, 5'd0, 64'h0,         0, 5'd0,  64'h0,    0, 0, 0, 0, 5'd0, 64'h0,         32'h8,        0);
        tbl[2]  = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd3, 64'hDEAD_BEEF, 0, 5'd0,  64'h0,    0, 1, 0, 1, 5'd3, 64'hDEAD_BEEF, 32'h8,        0);
        tbl[3]  = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0,         0, 5'd0,  64'h0,    0, 0, 0, 0, 5'd3, 64'hDEAD_BEEF, 32'h0,        1);
        tbl[4]  = mk(0, 1, 5'd5, 5'd0, 5'd0, 0, 5'd0, 64'h0,         0, 5'd0,  64'h0,    0, 0, 0, 0, 5'd3, 64'hDEAD_BEEF, 32'h20,       0);
        tbl[5]  = mk(0, 1, 5'd6, 5'd5, 5'd1, 0, 5'd0, 64'h0,         0, 5'd0,  64'h0,    1, 0, 0, 0, 5'd3, 64'hDEAD_BEEF, 32'h20,       0);
        tbl[6]  = mk(0, 1, 5'd5, 5'd1, 5'd2, 0, 5'd0, 64'h0,         1, 5'd5,  64'h55,   1, 0, 1, 1, 5'd5, 64'h55,        32'h20,       0);
        tbl[7]  = mk(0, 1, 5'd6, 5'd5, 5'd1, 0, 5'd0, 64'h0,         0, 5'd0,  64'h0,    1, 0, 0, 0, 5'd5, 64'h55,        32'h0,        1);
        tbl[8]  = mk(0, 1, 5'd6, 5'd5, 5'd1, 0, 5'd0, 64'h0,         0, 5'd0,  64'h0,    0, 0, 0, 0, 5'd5, 64'h55,        32'h40,       0);
        tbl[9]  = mk(0, 1, 5'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0,         1, 5'd0,  64'h1234, 0, 0, 1, 1, 5'd0, 64'h1234,      32'h40,       0);
        tbl[10] = mk(0, 1, 5'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0,         0, 5'd0,  64'h0,    0, 0, 0, 0, 5'd0, 64'h1234,      32'h40,       0);
        tbl[11] = mk(0, 1, 5'd2, 5'd0, 5'd0, 1, 5'd6, 64'h66,        0, 5'd0,  64'h0,    0, 1, 0, 1, 5'd6, 64'h66,        32'h44,       0);
        tbl[12] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0,         1, 5'd2,  64'h22,   0, 0, 1, 1, 5'd2, 64'h22,        32'h04,       0);
        tbl[13] = mk(0, 1, 5'd7, 5'd1, 5'd3, 0, 5'd0, 64'h0,         0, 5'd0,  64'h0,    0, 0, 0, 0, 5'd2, 64'h22,        32'h80,       0);
        tbl[14] = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd9, 64'h99,        0, 5'd0,  64'h0,    0, 1, 0, 1, 5'd9, 64'h99,        32'h80,       0);
        tbl[15] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0,         0, 5'd0,  64'h0,    0, 0, 0, 0, 5'd9, 64'h99,        32'h80,       0);
        tbl[16] = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd7, 64'h77,        1, 5'd10, 64'hAA,   0, 0, 1, 1, 5'd10, 64'hAA,       32'h80,       0);
        tbl[17] = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd7, 64'h77,        0, 5'd0,  64'h0,    0, 1, 0, 1, 5'd7, 64'h77,        32'h80,       0);
        tbl[18] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0,         0, 5'd0,  64'h0,    0, 0, 0, 0, 5'd7, 64'h77,        32'h0,        1);

        idle_in(1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 19; i++) begin
            run_vec(tbl[i], i);
        end

        // Round robin from reset: both requesters valid for four cycles.
        idle_in(1'b1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd11, 64'hA1, 1'b1, 5'd12, 64'hB2);
            #3;
            chk("rr_alu_ready", k, 64'(alu_ready), 64'((k % 2) == 0));
            chk("rr_lsu_ready", k, 64'(lsu_ready), 64'((k % 2) == 1));
            @(posedge clk);
            #1;
            chk("rr_wen", k, 64'(wen), 64'd1);
            chk("rr_vd",  k, 64'(vd),  (k % 2) == 0 ? 64'd11 : 64'd12);
        end
        idle_in(1'b0);
        @(posedge clk);
        #1;
        chk("rr_wen_drop", 0, 64'(wen), 64'd0);
        chk("rr_vd_hold",  0, 64'(vd),  64'd12);

        // Fill busy with 8..11, launch a write to 8, then reset while wen=1.
        for (int r = 8; r < 12; r++) begin
            drive(1'b0, 1'b1, 5'(r), 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
            #3;
            chk("fill_stall", r, 64'(iss_stall), 64'd0);
            @(posedge clk);
            #1;
        end
        chk("fill_busy", 0, 64'(busy), 64'h0F00);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd8, 64'hC8, 1'b0, 5'd0, 64'd0);
        @(posedge clk);
        #1;
        chk("pre_rst_wen",  0, 64'(wen),  64'd1);
        chk("pre_rst_busy", 0, 64'(busy), 64'h0F00);
        drive(1'b1, 1'b1, 5'd12, 5'd8, 5'd9, 1'b1, 5'd9, 64'hC9, 1'b1, 5'd10, 64'hCA);
        #3;
        chk("rst_stall",     0, 64'(iss_stall), 64'd0);
        chk("rst_alu_ready", 0, 64'(alu_ready), 64'd0);
        chk("rst_lsu_ready", 0, 64'(lsu_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_wen",   0, 64'(wen),  64'd0);
        chk("rst_busy",  0, 64'(busy), 64'd0);
        chk("rst_vd",    0, 64'(vd),   64'd0);
        chk("rst_wdata", 0, wdata,     64'd0);
        chk("rst_idle",  0, 64'(idle), 64'd1);
        // Pointer favoured LSU before reset; after reset ALU must win.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 64'hC9, 1'b1, 5'd10, 64'hCA);
        #3;
        chk("post_rst_alu_ready", 0, 64'(alu_ready), 64'd1);
        chk("post_rst_lsu_ready", 0, 64'(lsu_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("post_rst_vd", 0, 64'(vd), 64'd9);
        idle_in(1'b0);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vreg_wb_sched.md
VREG_WB_SCHED -- requirements
Module: vreg_wb_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports in this order: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these parameters (name, default, meaning): VLEN, 64, write-data width; NREG, 32, number of vector registers; IDX_W, 5, register index width.
REQ-003 Issue ports SHALL be:
- iss_valid  in  1  instruction offered for issue
- iss_vd  in  IDX_W  destination index
- iss_vs1  in  IDX_W  source 1 index
- iss_vs2  in  IDX_W  source 2 index
- iss_stall  out  1  hazard; issue not accepted this cycle
REQ-004 ALU writeback ports SHALL be: alu_valid in 1; alu_vd in IDX_W; alu_wdata in VLEN; alu_ready out 1.
REQ-005 LSU writeback ports SHALL be: lsu_valid in 1; lsu_vd in IDX_W; lsu_wdata in VLEN; lsu_ready out 1.
REQ-006 Register-file write ports SHALL be: wen out 1; vd out IDX_W; wdata out VLEN. All three are registered and drive the file's single write port.
REQ-007 Status ports SHALL be: busy out NREG (pending-write bit per register); idle out 1 (busy==0 and wen==0).

Function
REQ-008 iss_stall SHALL be combinational and equal iss_valid & (busy[iss_vs1] | busy[iss_vs2] | busy[iss_vd]).
- This covers RAW and WAW hazards.
- busy[0] is constantly 0.
REQ-009 An issue SHALL be accepted when iss_valid & !iss_stall; at that clock edge busy[iss_vd] is set, except when iss_vd==0.
REQ-010 Writeback arbitration SHALL be two-way round-robin with a one-bit priority pointer.
- With a single requester valid, that requester is granted.
- With both valid, the pointed-to requester is granted.
REQ-011 alu_ready and lsu_ready SHALL be combinational grant signals: at most one high per cycle, never high without the matching valid, and independent of the ready signals themselves.
REQ-012 A handshake SHALL complete when valid & ready. The requester holds vd and wdata stable until that point.
REQ-013 After each completed handshake, the pointer SHALL point to the non-granted requester. With no grant, the pointer holds.
REQ-014 On a grant at edge N, wen/vd/wdata SHALL carry the granted transaction during cycle N+1. If there is no grant, wen=0 and vd/wdata hold their previous values.
- Throughput: one write per cycle.
- Latency: one cycle from handshake to wen.
REQ-015 busy[vd] SHALL clear at the edge ending a cycle in which wen=1, the same edge at which the register file captures wdata. A dependent issue therefore unstalls the following cycle and reads fresh data.
REQ-016 A write to vd==0 SHALL be granted and drive wen=1, vd=0 (the file discards it). It does not change busy.
REQ-017 A set (REQ-009) and a clear (REQ-015) on different indices at the same edge SHALL both take effect. The same index cannot coincide, because WAW stalls the issue.
REQ-018 A writeback to a register whose busy bit is 0 SHALL still be written. busy stays 0; no error is flagged.

Reset
REQ-019 While rst=1 at a clock edge, the block SHALL set: busy=0; wen=0; vd=0; wdata=0; pointer=ALU.
REQ-020 While rst=1, alu_ready and lsu_ready SHALL be 0 and iss_stall SHALL be 0.
REQ-021 Reset asserted mid-operation SHALL drop any in-flight registered write (wen=0 the next cycle) and clear all busy bits. No handshake completes during reset.

Structure
REQ-022 Package vreg_pkg SHALL hold the VLEN, NREG and IDX_W constants and a requester-id enum (REQ_ALU=0, REQ_LSU=1), shared with the register file and the execution units.
REQ-023 The round-robin grant logic with its pointer SHALL be one sub-module, rr_arb2. Scoreboard and output registers stay in vreg_wb_sched.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then issue vd=3 -> busy[3]=1 next cycle. ALU writes vd=3, 0xDEAD_BEEF -> wen=1, vd=3 one cycle later; busy[3]=0 after that edge; idle=1.
- With busy[5]=1, issue vs1=5 -> iss_stall=1 until the cycle after wen with vd=5. Issue vd=5 while busy[5]=1 -> stalled.
- ALU and LSU both valid continuously for 4 cycles after reset -> grants ALU, LSU, ALU, LSU; wen high 4 consecutive cycles.
- LSU writes vd=0 -> wen=1, vd=0; busy unchanged. Issue vd=0 -> never stalls, busy[0] stays 0.
- Same edge: issue vd=7 while wen writes vd=2 -> busy[7]=1 and busy[2]=0 after the edge.
- rst pulsed while wen=1 and busy=0x0000_0F00 -> next cycle wen=0, busy=0, pointer=ALU.
